turn_sequencer: RTL and testbench

- Top-level battle state machine; the initiator side of the turn handshake that the player-attack and enemy-attack turn modules respond to.
- Drives a registered 4-bit state code to every turn module and waits for each module's busy/finished handshake.
- Decides the next turn from enemy/player HP.
- Sits between button inputs and the turn modules; state_out also selects which module's pixels the top-level mux shows.

---
 rtl/battle_pkg.sv | 25 ++
 rtl/turn_sequencer_rise_edge.sv | 23 ++
 rtl/turn_sequencer.sv | 179 +++++++++++++++++
 tb/tb_turn_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// Shared battle definitions: game state codes seen by the sequencer, the turn
// modules and the top-level pixel mux.
package battle_pkg;

  typedef enum logic [3:0] {
    ST_MENU       = 4'b0000,
    ST_PLAYER_ATK = 4'b0001,
    ST_ENEMY_ATK  = 4'b0010,
    ST_TITLE      = 4'b1010,
    ST_GAME_OVER  = 4'b1110,
    ST_WIN        = 4'b1111
  } state_t;

  localparam logic [3:0] MENU_CODE       = 4'b0000;
  localparam logic [3:0] PLAYER_ATK_CODE = 4'b0001;
  localparam logic [3:0] ENEMY_ATK_CODE  = 4'b0010;
  localparam logic [3:0] TITLE_CODE      = 4'b1010;
  localparam logic [3:0] GAME_OVER_CODE  = 4'b1110;
  localparam logic [3:0] WIN_CODE        = 4'b1111;

  function automatic logic is_turn(input state_t s);
    return (s == ST_PLAYER_ATK) || (s == ST_ENEMY_ATK);
  endfunction

endpackage

// File: rtl/turn_sequencer_rise_edge.sv
// One-bit rising-edge detector with a registered pulse output, so the pulse
// appears one cycle after the first high sample of the level.
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev_r;

  // Previous-level register and registered edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      prev_r <= level;
      pulse  <= level & ~prev_r;
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Battle state machine: initiates each attack turn by changing state_out and
// waits for the active turn module's busy/finished handshake.
module turn_sequencer
  import battle_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1000,
  parameter int HP_W        = 11,
  parameter int ROUND_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic               confirm_in,
  input  logic               player_busy_in,
  input  logic               player_finished_in,
  input  logic               enemy_busy_in,
  input  logic               enemy_finished_in,
  input  logic [HP_W-1:0]    enemy_hp_in,
  input  logic [HP_W-1:0]    player_hp_in,
  output logic [3:0]         state_out,
  output logic [ROUND_W-1:0] round_out,
  output logic               restart_out,
  output logic               fault_out
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  state_t             state_r;
  state_t             next_state_s;
  logic               busy_seen_r;
  logic [TMR_W-1:0]   timer_r;
  logic [ROUND_W-1:0] round_r;
  logic               restart_r;
  logic               fault_r;
  logic               start_edge_s;
  logic               confirm_edge_s;
  logic               turn_busy_s;
  logic               turn_fin_s;
  logic               accept_s;
  logic               timeout_s;
  logic               restart_set_s;
  logic               round_inc_s;
  logic               fault_set_s;
  logic               state_change_s;

  rise_edge u_start_edge (
    .clk   (clk),
    .rst   (rst),
    .level (start_in),
    .pulse (start_edge_s)
  );

  rise_edge u_confirm_edge (
    .clk   (clk),
    .rst   (rst),
    .level (confirm_in),
    .pulse (confirm_edge_s)
  );

  // Next-state decision; only the active turn module's handshake is looked at.
  always_comb begin
    next_state_s  = state_r;
    restart_set_s = 1'b0;
    round_inc_s   = 1'b0;
    fault_set_s   = 1'b0;
    turn_busy_s   = 1'b0;
    turn_fin_s    = 1'b0;
    if (state_r == ST_PLAYER_ATK) begin
      turn_busy_s = player_busy_in;
      turn_fin_s  = player_finished_in;
    end else if (state_r == ST_ENEMY_ATK) begin
      turn_busy_s = enemy_busy_in;
      turn_fin_s  = enemy_finished_in;
    end else begin
      turn_busy_s = 1'b0;
      turn_fin_s  = 1'b0;
    end
    // A finished level without any busy this turn is stale from the last turn.
    accept_s  = turn_fin_s & (busy_seen_r | turn_busy_s);
    timeout_s = (timer_r == TMR_LAST) & ~busy_seen_r & ~turn_busy_s;
    case (state_r)
      ST_TITLE: begin
        if (start_edge_s) begin
          next_state_s  = ST_MENU;
          restart_set_s = 1'b1;
        end else begin
          next_state_s = ST_TITLE;
        end
      end
      ST_MENU: begin
        if (confirm_edge_s) begin
          next_state_s = ST_PLAYER_ATK;
        end else begin
          next_state_s = ST_MENU;
        end
      end
      ST_PLAYER_ATK: begin
        if (accept_s) begin
          next_state_s = (enemy_hp_in == {HP_W{1'b0}}) ? ST_WIN : ST_ENEMY_ATK;
        end else if (timeout_s) begin
          next_state_s = ST_MENU;
          fault_set_s  = 1'b1;
        end else begin
          next_state_s = ST_PLAYER_ATK;
        end
      end
      ST_ENEMY_ATK: begin
        if (player_hp_in == {HP_W{1'b0}}) begin
          next_state_s = ST_GAME_OVER;
        end else if (accept_s) begin
          next_state_s = ST_MENU;
          round_inc_s  = 1'b1;
        end else if (timeout_s) begin
          next_state_s = ST_MENU;
          fault_set_s  = 1'b1;
        end else begin
          next_state_s = ST_ENEMY_ATK;
        end
      end
      ST_GAME_OVER, ST_WIN: begin
        if (start_edge_s) begin
          next_state_s = ST_TITLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = ST_TITLE;
    endcase
    state_change_s = (next_state_s != state_r);
  end

  // State register and the pulse/sticky outputs derived from the decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_TITLE;
      restart_r <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      restart_r <= restart_set_s;
      fault_r   <= fault_r | fault_set_s;
    end
  end

  // Handshake tracking and the acknowledge watchdog, both restarted per state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_seen_r <= 1'b0;
      timer_r     <= {TMR_W{1'b0}};
    end else if (state_change_s) begin
      busy_seen_r <= 1'b0;
      timer_r     <= {TMR_W{1'b0}};
    end else if (is_turn(state_r)) begin
      busy_seen_r <= busy_seen_r | turn_busy_s;
      timer_r     <= busy_seen_r ? timer_r : timer_r + TMR_W'(1);
    end else begin
      busy_seen_r <= busy_seen_r;
      timer_r     <= timer_r;
    end
  end

  // Completed-round counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_r <= {ROUND_W{1'b0}};
    end else if (round_inc_s && (round_r != {ROUND_W{1'b1}})) begin
      round_r <= round_r + ROUND_W'(1);
    end else begin
      round_r <= round_r;
    end
  end

  assign state_out   = state_r;
  assign round_out   = round_r;
  assign restart_out = restart_r;
  assign fault_out   = fault_r;

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: directed battle scenarios followed by randomized
// full rounds judged against a turn-level outcome model.
module tb_turn_sequencer;

  localparam logic [3:0] C_TITLE = 4'b1010;
  localparam logic [3:0] C_MENU  = 4'b0000;
  localparam logic [3:0] C_PATK  = 4'b0001;
  localparam logic [3:0] C_EATK  = 4'b0010;
  localparam logic [3:0] C_OVER  = 4'b1110;
  localparam logic [3:0] C_WIN   = 4'b1111;

  logic        clk;
  logic        rst;
  logic        start_in;
  logic        confirm_in;
  logic        player_busy_in;
  logic        player_finished_in;
  logic        enemy_busy_in;
  logic        enemy_finished_in;
  logic [10:0] enemy_hp_in;
  logic [10:0] player_hp_in;
  logic [3:0]  state_out;
  logic [7:0]  round_out;
  logic        restart_out;
  logic        fault_out;

  int errors = 0;
  int checks = 0;
  int rounds_model = 0;
  bit fault_model = 1'b0;

  turn_sequencer #(.ACK_TIMEOUT(16), .HP_W(11), .ROUND_W(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .start_in           (start_in),
    .confirm_in         (confirm_in),
    .player_busy_in     (player_busy_in),
    .player_finished_in (player_finished_in),
    .enemy_busy_in      (enemy_busy_in),
    .enemy_finished_in  (enemy_finished_in),
    .enemy_hp_in        (enemy_hp_in),
    .player_hp_in       (player_hp_in),
    .state_out          (state_out),
    .round_out          (round_out),
    .restart_out        (restart_out),
    .fault_out          (fault_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_round();
    return (rounds_model > 255) ? 32'd255 : 32'(rounds_model);
  endfunction

  task automatic check_all(input string tag, input logic [3:0] st);
    check({tag, "_state"}, state_out, st);
    check({tag, "_round"}, round_out, exp_round());
    check({tag, "_fault"}, fault_out, fault_model);
  endtask

  task automatic press_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    tick();
  endtask

  task automatic press_confirm();
    confirm_in = 1'b1;
    tick();
    confirm_in = 1'b0;
    tick();
  endtask

  // From GAME_OVER or WIN back through TITLE into a fresh MENU.
  task automatic back_to_menu(input string tag);
    press_start();
    check({tag, "_title"}, state_out, C_TITLE);
    press_start();
    check_all({tag, "_menu"}, C_MENU);
    check({tag, "_restart"}, restart_out, 1'b1);
    tick();
    check({tag, "_restart_end"}, restart_out, 1'b0);
  endtask

  // One acknowledged turn: busy after bdel idle cycles, then finished either
  // together with busy or fdel cycles later once busy has dropped.
  task automatic run_turn(input bit enemy, input int bdel, input int fdel,
                          input bit same_cycle, input bit noise);
    logic [3:0] code;
    code = enemy ? C_EATK : C_PATK;
    for (int i = 0; i < bdel; i++) begin
      start_in   = (i == 0) ? noise : 1'b0;
      confirm_in = (i == 0) ? noise : 1'b0;
      tick();
      check("turn_idle", state_out, code);
    end
    start_in   = 1'b0;
    confirm_in = 1'b0;
    if (enemy) enemy_busy_in = 1'b1; else player_busy_in = 1'b1;
    if (same_cycle) begin
      if (enemy) enemy_finished_in = 1'b1; else player_finished_in = 1'b1;
      tick();
    end else begin
      for (int i = 0; i < fdel; i++) begin
        tick();
        check("turn_busy", state_out, code);
      end
      if (enemy) enemy_busy_in = 1'b0; else player_busy_in = 1'b0;
      if (enemy) enemy_finished_in = 1'b1; else player_finished_in = 1'b1;
      tick();
    end
    player_busy_in     = 1'b0;
    enemy_busy_in      = 1'b0;
    player_finished_in = 1'b0;
    enemy_finished_in  = 1'b0;
  endtask

  initial begin
    int bdel;
    rst = 1'b1;
    start_in = 1'b0;
    confirm_in = 1'b0;
    player_busy_in = 1'b0;
    player_finished_in = 1'b0;
    enemy_busy_in = 1'b0;
    enemy_finished_in = 1'b0;
    enemy_hp_in = 11'd100;
    player_hp_in = 11'd500;

    // Reset state.
    tick(); tick(); tick();
    check_all("reset", C_TITLE);
    check("reset_restart", restart_out, 1'b0);
    rst = 1'b0;
    tick();
    check("title_idle", state_out, C_TITLE);

    // Start edge: one cycle of latency from the registered edge, then MENU.
    start_in = 1'b1;
    tick();
    check("start_lat_state", state_out, C_TITLE);
    check("start_lat_restart", restart_out, 1'b0);
    start_in = 1'b0;
    tick();
    check_all("menu_entry", C_MENU);
    check("restart_pulse", restart_out, 1'b1);
    tick();
    check("restart_once", restart_out, 1'b0);

    // Player turn with enemy alive, then enemy turn completes one round.
    press_confirm();
    check("player_entry", state_out, C_PATK);
    run_turn(1'b0, 3, 50, 1'b0, 1'b0);
    check_all("to_enemy", C_EATK);
    run_turn(1'b1, 2, 5, 1'b1, 1'b0);
    rounds_model++;
    check_all("round1", C_MENU);

    // Enemy HP zero at player finish wins; start returns to title.
    press_confirm();
    enemy_hp_in = 11'd0;
    run_turn(1'b0, 1, 4, 1'b0, 1'b0);
    check_all("win", C_WIN);
    enemy_hp_in = 11'd100;
    back_to_menu("after_win");

    // Player HP hits zero mid enemy turn: immediate game over, no round.
    press_confirm();
    run_turn(1'b0, 2, 3, 1'b0, 1'b0);
    check("abort_enemy_entry", state_out, C_EATK);
    enemy_busy_in = 1'b1;
    tick(); tick(); tick();
    check("abort_busy", state_out, C_EATK);
    player_hp_in = 11'd0;
    tick();
    check_all("game_over", C_OVER);
    enemy_busy_in = 1'b0;
    player_hp_in = 11'd500;
    back_to_menu("after_over");

    // Stale finished with no busy: ignored, watchdog trips after 16 cycles.
    player_finished_in = 1'b1;
    press_confirm();
    check("stale_entry", state_out, C_PATK);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("stale_wait_state", state_out, C_PATK);
      check("stale_wait_fault", fault_out, 1'b0);
    end
    tick();
    fault_model = 1'b1;
    check_all("timeout", C_MENU);
    player_finished_in = 1'b0;

    // Randomized rounds until the round counter has saturated.
    for (int it = 0; it < 420 && rounds_model < 258; it++) begin
      logic [10:0] ehp;
      press_confirm();
      check("rnd_player_entry", state_out, C_PATK);
      ehp = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
      enemy_hp_in = ehp;
      bdel = $urandom_range(0, 10);
      run_turn(1'b0, bdel, $urandom_range(1, 6), 1'($urandom_range(0, 1)),
               (bdel >= 2) && ($urandom_range(0, 1) == 1));
      if (ehp == 11'd0) begin
        check_all("rnd_win", C_WIN);
        enemy_hp_in = 11'd100;
        back_to_menu("rnd_win_back");
      end else begin
        check_all("rnd_enemy", C_EATK);
        if ($urandom_range(0, 15) == 0) begin
          enemy_busy_in = 1'b1;
          tick();
          player_hp_in = 11'd0;
          tick();
          check_all("rnd_over", C_OVER);
          enemy_busy_in = 1'b0;
          player_hp_in = 11'd500;
          back_to_menu("rnd_over_back");
        end else begin
          bdel = $urandom_range(0, 10);
          run_turn(1'b1, bdel, $urandom_range(1, 6), 1'($urandom_range(0, 1)),
                   (bdel >= 2) && ($urandom_range(0, 1) == 1));
          rounds_model++;
          check_all("rnd_round", C_MENU);
        end
      end
    end
    check("saturated", round_out, 32'd255);

    // Reset in the middle of a turn.
    press_confirm();
    check("midreset_entry", state_out, C_PATK);
    player_busy_in = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rounds_model = 0;
    fault_model = 1'b0;
    check_all("midreset", C_TITLE);
    rst = 1'b0;
    player_busy_in = 1'b0;
    tick();
    check("midreset_hold", state_out, C_TITLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
